// File: rtl/mem_rd_pkg.sv
// Shared definitions for the burst read sequencer and its helpers.
//   AW             : memory address width (memory depth is 2**AW)
//   DW             : memory data word width
//   MEM_RD_LATENCY : cycles from a read being issued to its data being valid
//   state_e        : sequencer FSM states
package mem_rd_pkg;

    localparam int AW             = 3;
    localparam int DW             = 8;
    localparam int MEM_RD_LATENCY = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_burst_reader_chk.sv
// Assertion checker for mem_burst_reader.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset (checks disabled in reset)
//   rd_en_i    : read issued to the memory this cycle
//   push_i     : FIFO write this cycle
//   pop_i      : FIFO read this cycle
//   count_i    : FIFO occupancy
module mem_burst_reader_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rd_en_i,
    input logic          push_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);
    import mem_rd_pkg::*;

    logic rd_pipe_q [MEM_RD_LATENCY];

    // Delay line of issued reads, one stage per cycle of memory latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_RD_LATENCY; i++) begin
                rd_pipe_q[i] <= 1'b0;
            end
        end else begin
            rd_pipe_q[0] <= rd_en_i;
            for (int i = 1; i < MEM_RD_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (count_i == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (count_i == CW'(0))));

    a_push_follows_read: assert property (@(posedge clk) disable iff (!rst_n)
        push_i == rd_pipe_q[MEM_RD_LATENCY-1]);

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset (flushes the FIFO)
//   push_i       : write push_data_i this cycle
//   push_data_i  : word to write
//   pop_i        : remove the head word this cycle (only legal when valid_o)
//   head_o       : current head word, 0 when empty
//   valid_o      : FIFO holds at least one word
//   count_o      : number of words held, 0..DEPTH
// Simultaneous push and pop leave the count unchanged and keep word order.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage write; contents need no reset because count_q gates visibility.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head word is forced to zero while empty so stale storage never leaks out.
    always_comb begin
        if (count_q != '0) begin
            head_o  = mem_q[rd_ptr_q];
            valid_o = 1'b1;
        end else begin
            head_o  = '0;
            valid_o = 1'b0;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read sequencer for the 8x8 registered-read memory.
// Takes a (base_addr, len) command, issues len sequential reads (address wraps
// mod 2**AW), captures each word one cycle after its read and streams the words
// out through a small FIFO on a valid/ready interface.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   start, base_addr,len: burst command, sampled every cycle, accepted only in IDLE
//   busy                : burst in progress
//   done                : one-cycle pulse after the last word is accepted (or len==0)
//   mem_addr, mem_rd_en : registered read request to the memory
//   mem_rdata           : memory data, valid the cycle after mem_rd_en
//   out_data, out_valid : FIFO head word and non-empty flag
//   out_ready           : downstream accepts the head word
module mem_burst_reader #(
    parameter int AW         = mem_rd_pkg::AW,
    parameter int DW         = mem_rd_pkg::DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    import mem_rd_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          mem_rd_en_q;
    logic [AW-1:0] mem_addr_q;
    logic          inflight_q;
    logic [AW:0]   len_q;
    logic [AW:0]   issued_q;
    logic [AW:0]   out_rem_q;

    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   reserved_s;
    logic          out_valid_s;
    logic          pop_s;
    logic          last_pop_s;
    logic          issue_d;

    // Issue decision and output handshake, built from registered state only so
    // that out_ready never reaches mem_rd_en combinationally.
    always_comb begin
        // Slots already committed: words stored, word arriving now, read issued now.
        reserved_s = {1'b0, fifo_count_s}
                   + {{CW{1'b0}}, inflight_q}
                   + {{CW{1'b0}}, mem_rd_en_q};
        if ((state_q == RUN) && (issued_q < len_q) &&
            (reserved_s < (CW+1)'(FIFO_DEPTH))) begin
            issue_d = 1'b1;
        end else begin
            issue_d = 1'b0;
        end
        pop_s = out_valid_s && out_ready;
        if (pop_s && (out_rem_q == (AW+1)'(1))) begin
            last_pop_s = 1'b1;
        end else begin
            last_pop_s = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs; the command's first read is issued
    // directly from IDLE so it appears the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            inflight_q  <= 1'b0;
            len_q       <= '0;
            issued_q    <= '0;
            out_rem_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
            inflight_q  <= mem_rd_en_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            len_q       <= len;
                            out_rem_q   <= len;
                            issued_q    <= (AW+1)'(1);
                            mem_addr_q  <= base_addr;
                            mem_rd_en_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_d) begin
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= mem_addr_q + AW'(1);
                        issued_q    <= issued_q + (AW+1)'(1);
                    end
                    if (pop_s) begin
                        out_rem_q <= out_rem_q - (AW+1)'(1);
                    end
                    if (last_pop_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata),
        .pop_i       (pop_s),
        .head_o      (out_data),
        .valid_o     (out_valid_s),
        .count_o     (fifo_count_s)
    );

    mem_burst_reader_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (mem_rd_en_q),
        .push_i  (inflight_q),
        .pop_i   (pop_s),
        .count_i (fifo_count_s)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_s;

endmodule
